// File: rtl/ca_vga_pkg.sv
// Shared definitions for the 1-D cellular-automaton VGA renderer.
//   - default VGA active-area sizes
//   - well-known Wolfram rule numbers
//   - 6-bit RRGGBB colour type
//   - seed-fill FSM state encoding and the LFSR tap mask
package ca_vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic [7:0] RULE_30  = 8'd30;
  localparam logic [7:0] RULE_90  = 8'd90;
  localparam logic [7:0] RULE_110 = 8'd110;

  // {R[1:0], G[1:0], B[1:0]}
  typedef logic [5:0] rgb6_t;

  // Seed-fill FSM state encoding
  typedef logic [0:0] fill_state_t;
  localparam fill_state_t ST_IDLE = 1'b0;
  localparam fill_state_t ST_FILL = 1'b1;

  // Right-shifting Fibonacci LFSR, taps 16,14,13,11 -> register bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/ca1d_vga_renderer_if.sv
// Video bus between the sync generator side and the renderer.
//   pix_x, pix_y   : current beam position
//   video_active   : display enable
//   rgb            : registered pixel colour back from the renderer
// master = timing source / pin mux side, slave = renderer.
interface ca1d_vga_renderer_if;
  import ca_vga_pkg::*;

  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_active;
  rgb6_t      rgb;

  modport master (
    output pix_x,
    output pix_y,
    output video_active,
    input  rgb
  );

  modport slave (
    input  pix_x,
    input  pix_y,
    input  video_active,
    output rgb
  );

endinterface

// File: rtl/ca1d_next_row.sv
// Combinational next-generation logic for a 1-D elementary automaton.
//   row      : current generation, bit i = cell i, cell 0 leftmost
//   rule     : Wolfram rule number, indexed by {left, centre, right}
//   wrap     : 1 = toroidal edges, 0 = cells outside the grid read as 0
//   next_row : following generation
module ca1d_next_row #(
  parameter int GRID_W = 100
) (
  input  logic [GRID_W-1:0] row,
  input  logic [7:0]        rule,
  input  logic              wrap,
  output logic [GRID_W-1:0] next_row
);

  // Row padded with one neighbour on each side:
  // ext[0] is the left neighbour of cell 0, ext[i+1] is cell i,
  // ext[GRID_W+1] is the right neighbour of cell GRID_W-1.
  logic [GRID_W+1:0] ext;

  always_comb begin
    ext      = {wrap & row[0], row, wrap & row[GRID_W-1]};
    next_row = '0;
    for (int i = 0; i < GRID_W; i++) begin
      next_row[i] = rule[{ext[i], ext[i+1], ext[i+2]}];
    end
  end

endmodule

// File: rtl/ca1d_vga_renderer.sv
// 1-D elementary cellular-automaton renderer on the pixel clock.
// One GRID_W-bit generation is displayed per cell row; the displayed row
// (line_q) advances one generation at the end of every cell row, and is
// reloaded from the frame's top row (top_q) at each frame boundary.
//
// Ports
//   clk, rst_n  : pixel clock, synchronous active-low reset
//   vga         : video bus (pix_x, pix_y, video_active in; rgb out, 1-cycle latency)
//   rule_in     : Wolfram rule, latched at the frame boundary
//   color_in    : live-cell colour, latched at the frame boundary
//   wrap_en     : toroidal edges, latched at the frame boundary
//   scroll_en   : top row advances one generation per frame
//   seed_req    : one-cycle pulse requesting a reseed at the next frame boundary
//   seed_mode   : 0 = centre cell, 1 = LFSR fill; captured with seed_req
//   busy        : high during the LFSR fill
//   frame_rule  : rule in force for the current frame
//   fsm_state   : seed-fill FSM state
//
// Request protocol: seed_req is accepted in any cycle where no seed is
// pending and busy is low; it is then held internally until the next frame
// boundary. Requests arriving while a seed is pending or busy is high are
// dropped. busy is high for exactly GRID_W cycles starting the cycle after
// the frame boundary that starts an LFSR fill.
module ca1d_vga_renderer
  import ca_vga_pkg::*;
#(
  parameter int          H_ACTIVE  = H_ACTIVE_DEF,
  parameter int          V_ACTIVE  = V_ACTIVE_DEF,
  parameter int          GRID_W    = 100,
  parameter int          LOG_CELL  = 2,
  parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  ca1d_vga_renderer_if.slave  vga,
  input  logic [7:0]          rule_in,
  input  rgb6_t               color_in,
  input  logic                wrap_en,
  input  logic                scroll_en,
  input  logic                seed_req,
  input  logic                seed_mode,
  output logic                busy,
  output logic [7:0]          frame_rule,
  output fill_state_t         fsm_state
);

  localparam int PAD_LEFT = (H_ACTIVE - (GRID_W << LOG_CELL)) / 2;
  localparam int CNT_W    = (GRID_W > 2) ? $clog2(GRID_W) : 1;

  localparam logic [GRID_W-1:0] CENTRE_ROW = GRID_W'(1) << (GRID_W / 2);
  localparam logic [CNT_W-1:0]  FILL_LAST  = CNT_W'(GRID_W - 1);

  fill_state_t       state;
  logic [CNT_W-1:0]  fill_cnt;
  logic [15:0]       lfsr;
  logic              seed_pend;
  logic              seed_mode_q;
  logic [7:0]        rule_q;
  rgb6_t             colour_q;
  logic              wrap_q;
  logic [GRID_W-1:0] top_q;
  logic [GRID_W-1:0] line_q;

  logic [GRID_W-1:0] top_next;
  logic [GRID_W-1:0] line_next;

  // The top row only advances at a frame boundary, where the freshly
  // sampled rule/wrap become the new frame's settings, so it evaluates
  // against the live inputs rather than the shadows.
  ca1d_next_row #(.GRID_W(GRID_W)) u_next_top (
    .row      (top_q),
    .rule     (rule_in),
    .wrap     (wrap_en),
    .next_row (top_next)
  );

  ca1d_next_row #(.GRID_W(GRID_W)) u_next_line (
    .row      (line_q),
    .rule     (rule_q),
    .wrap     (wrap_q),
    .next_row (line_next)
  );

  // Timing events
  logic frame_edge;
  logic row_edge;

  always_comb begin
    frame_edge = (vga.pix_y == 10'(V_ACTIVE)) && (vga.pix_x == '0);
    row_edge   = (vga.pix_x == 10'(H_ACTIVE)) && (vga.pix_y < 10'(V_ACTIVE)) &&
                 (&vga.pix_y[LOG_CELL-1:0]);
  end

  // Pixel-to-cell mapping; x_off wraps below PAD_LEFT, which the explicit
  // pix_x >= PAD_LEFT term rejects.
  logic [9:0] x_off;
  logic [9:0] cell_x;
  logic       in_grid;
  logic       cell_lit;

  always_comb begin
    x_off    = vga.pix_x - 10'(PAD_LEFT);
    cell_x   = x_off >> LOG_CELL;
    in_grid  = vga.video_active && (vga.pix_x >= 10'(PAD_LEFT)) &&
               (cell_x < 10'(GRID_W));
    cell_lit = |(line_q & (GRID_W'(1) << cell_x));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      fill_cnt    <= '0;
      lfsr        <= LFSR_INIT;
      seed_pend   <= 1'b0;
      seed_mode_q <= 1'b0;
      rule_q      <= RULE_30;
      colour_q    <= 6'b111111;
      wrap_q      <= 1'b0;
      top_q       <= CENTRE_ROW;
      line_q      <= CENTRE_ROW;
      vga.rgb     <= '0;
    end else begin
      if (seed_req && !seed_pend && (state != ST_FILL)) begin
        seed_pend   <= 1'b1;
        seed_mode_q <= seed_mode;
      end

      case (state)
        ST_FILL: begin
          // Bits enter at the right edge and march left, so the first LFSR
          // bit ends up in cell 0 after GRID_W shifts.
          top_q  <= {lfsr[0], top_q[GRID_W-1:1]};
          line_q <= {lfsr[0], line_q[GRID_W-1:1]};
          lfsr   <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
          if (fill_cnt == FILL_LAST) begin
            state     <= ST_IDLE;
            fill_cnt  <= '0;
            seed_pend <= 1'b0;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end

        default: begin
          if (frame_edge) begin
            rule_q   <= rule_in;
            colour_q <= color_in;
            wrap_q   <= wrap_en;
            if (seed_pend) begin
              if (seed_mode_q) begin
                state    <= ST_FILL;
                fill_cnt <= '0;
              end else begin
                top_q     <= CENTRE_ROW;
                line_q    <= CENTRE_ROW;
                seed_pend <= 1'b0;
              end
            end else if (scroll_en) begin
              top_q  <= top_next;
              line_q <= top_next;
            end else begin
              line_q <= top_q;
            end
          end else if (row_edge) begin
            line_q <= line_next;
          end
        end
      endcase

      vga.rgb <= (in_grid && cell_lit) ? colour_q : '0;
    end
  end

  assign busy       = (state == ST_FILL);
  assign frame_rule = rule_q;
  assign fsm_state  = state;

endmodule

// File: tb/tb_ca1d_vga_renderer.sv
module tb_ca1d_vga_renderer;
  import ca_vga_pkg::*;

  localparam int PAD_A = 120;
  localparam int PAD_B = 304;

  localparam logic [99:0] ROW_C     = 100'd1 << 50;
  localparam logic [99:0] ROW_R30_1 = 100'h7 << 49;
  localparam logic [99:0] ROW_R30_2 = 100'h13 << 48;
  localparam logic [99:0] ROW_R110_1 = 100'h3 << 49;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // DUT A: 100-cell grid
  ca1d_vga_renderer_if vif_a ();
  logic [7:0]  rule_a;
  rgb6_t       color_a;
  logic        wrap_a, scroll_a, seed_req_a, seed_mode_a;
  logic        busy_a;
  logic [7:0]  frame_rule_a;
  fill_state_t state_a;

  ca1d_vga_renderer dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga        (vif_a),
    .rule_in    (rule_a),
    .color_in   (color_a),
    .wrap_en    (wrap_a),
    .scroll_en  (scroll_a),
    .seed_req   (seed_req_a),
    .seed_mode  (seed_mode_a),
    .busy       (busy_a),
    .frame_rule (frame_rule_a),
    .fsm_state  (state_a)
  );

  // DUT B: 8-cell grid
  ca1d_vga_renderer_if vif_b ();
  logic [7:0]  rule_b;
  logic        wrap_b;
  logic        busy_b;
  logic [7:0]  frame_rule_b;
  fill_state_t state_b;

  ca1d_vga_renderer #(.GRID_W(8)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga        (vif_b),
    .rule_in    (rule_b),
    .color_in   (6'h3F),
    .wrap_en    (wrap_b),
    .scroll_en  (1'b0),
    .seed_req   (1'b0),
    .seed_mode  (1'b0),
    .busy       (busy_b),
    .frame_rule (frame_rule_b),
    .fsm_state  (state_b)
  );

  // standalone next-row blocks for the edge behaviour
  logic [7:0] nr_row, nr_zero, nr_wrap;
  ca1d_next_row #(.GRID_W(8)) u_nr_zero (
    .row (nr_row), .rule (8'd90), .wrap (1'b0), .next_row (nr_zero));
  ca1d_next_row #(.GRID_W(8)) u_nr_wrap (
    .row (nr_row), .rule (8'd90), .wrap (1'b1), .next_row (nr_wrap));

  // scoreboard check
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [9:0] x, input logic [9:0] y, input logic va);
    vif_a.pix_x = x; vif_a.pix_y = y; vif_a.video_active = va;
  endtask

  task automatic drive_b(input logic [9:0] x, input logic [9:0] y, input logic va);
    vif_b.pix_x = x; vif_b.pix_y = y; vif_b.video_active = va;
  endtask

  task automatic frame_edge_a();
    drive_a(10'd0, 10'd480, 1'b0); tick(); drive_a(10'd641, 10'd0, 1'b0);
  endtask

  task automatic frame_edge_b();
    drive_b(10'd0, 10'd480, 1'b0); tick(); drive_b(10'd641, 10'd0, 1'b0);
  endtask

  // row steps at every y in [y0, y1] whose low two bits are 3
  task automatic steps_a(input int y0, input int y1);
    for (int y = y0; y <= y1; y += 4) begin
      drive_a(10'd640, 10'(y), 1'b0); tick();
    end
    drive_a(10'd641, 10'd0, 1'b0);
  endtask

  task automatic steps_b(input int y0, input int y1);
    for (int y = y0; y <= y1; y += 4) begin
      drive_b(10'd640, 10'(y), 1'b0); tick();
    end
    drive_b(10'd641, 10'd0, 1'b0);
  endtask

  task automatic pixel_a(input int x, input int y, input logic va, output rgb6_t c);
    drive_a(10'(x), 10'(y), va); tick(); c = vif_a.rgb;
    drive_a(10'd641, 10'd0, 1'b0);
  endtask

  task automatic read_row_a(input int y, output logic [99:0] row);
    row = '0;
    for (int c = 0; c < 100; c++) begin
      drive_a(10'(PAD_A + 4 * c + 1), 10'(y), 1'b1); tick();
      row[c] = (vif_a.rgb != 6'd0);
    end
    drive_a(10'd641, 10'd0, 1'b0);
  endtask

  task automatic read_row_b(input int y, output logic [7:0] row);
    row = '0;
    for (int c = 0; c < 8; c++) begin
      drive_b(10'(PAD_B + 4 * c + 2), 10'(y), 1'b1); tick();
      row[c] = (vif_b.rgb != 6'd0);
    end
    drive_b(10'd641, 10'd0, 1'b0);
  endtask

  // reference models
  function automatic logic [99:0] ca_model(input logic [99:0] start, input logic [7:0] rule,
                                           input int gens);
    logic [99:0] r, n, lv, rv;
    r = start;
    for (int g = 0; g < gens; g++) begin
      lv = r << 1;
      rv = r >> 1;
      for (int i = 0; i < 100; i++) n[i] = rule[{lv[i], r[i], rv[i]}];
      r = n;
    end
    return r;
  endfunction

  function automatic logic [99:0] lfsr_row(input logic [15:0] seed);
    logic [15:0] s;
    logic [99:0] r;
    s = seed;
    for (int i = 0; i < 100; i++) begin
      r[i] = s[0];
      s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    end
    return r;
  endfunction

  initial begin
    logic [99:0] row;
    logic [7:0]  row8;
    rgb6_t       c;
    int          busy_cnt;

    rst_n = 1'b0;
    rule_a = 8'd30; color_a = 6'h3F; wrap_a = 1'b0; scroll_a = 1'b0;
    seed_req_a = 1'b0; seed_mode_a = 1'b0;
    rule_b = 8'd90; wrap_b = 1'b0;
    drive_a(10'd641, 10'd0, 1'b0);
    drive_b(10'd641, 10'd0, 1'b0);
    nr_row = 8'h00;
    tick(); tick();

    // reset state
    check("reset_rgb", vif_a.rgb, 6'd0);
    check("reset_busy", busy_a, 1'b0);
    check("reset_frame_rule", frame_rule_a, 8'd30);
    check("reset_state", state_a, ST_IDLE);
    rst_n = 1'b1;
    tick();

    // test 1: centre seed, rule 30
    read_row_a(0, row);
    check("t1_row0", row, ROW_C);
    pixel_a(320, 1, 1'b1, c); check("t1_px320", c, 6'h3F);
    pixel_a(323, 2, 1'b1, c); check("t1_px323", c, 6'h3F);
    pixel_a(319, 0, 1'b1, c); check("t1_px319", c, 6'h00);
    pixel_a(324, 3, 1'b1, c); check("t1_px324", c, 6'h00);
    steps_a(3, 3);
    read_row_a(4, row);
    check("t1_row4", row, ROW_R30_1);
    pixel_a(315, 4, 1'b1, c); check("t1_px315", c, 6'h00);
    pixel_a(316, 4, 1'b1, c); check("t1_px316", c, 6'h3F);
    pixel_a(327, 5, 1'b1, c); check("t1_px327", c, 6'h3F);
    pixel_a(328, 5, 1'b1, c); check("t1_px328", c, 6'h00);

    // test 3: rule change mid-frame takes effect only at the frame boundary
    steps_a(7, 99);
    rule_a = 8'd110;
    check("t3_rule_mid", frame_rule_a, 8'd30);
    read_row_a(100, row);
    check("t3_row25", row, ca_model(ROW_C, 8'd30, 25));
    steps_a(103, 115);
    read_row_a(116, row);
    check("t3_row29", row, ca_model(ROW_C, 8'd30, 29));
    check("t3_rule_pre_fb", frame_rule_a, 8'd30);
    frame_edge_a();
    check("t3_rule_post_fb", frame_rule_a, 8'd110);
    read_row_a(0, row);
    check("t3_new_row0", row, ROW_C);
    steps_a(3, 3);
    read_row_a(4, row);
    check("t3_r110_row1", row, ROW_R110_1);

    // test 2: 8-cell grid, rule 90, zero then wrap boundary
    frame_edge_b();
    check("t2_rule_b", frame_rule_b, 8'd90);
    steps_b(3, 15);
    read_row_b(16, row8);
    check("t2_row4_zero", row8, 8'h01);
    steps_b(19, 19);
    read_row_b(20, row8);
    check("t2_row5_zero", row8, 8'h02);
    wrap_b = 1'b1;
    frame_edge_b();
    read_row_b(0, row8);
    check("t2_row0_wrap", row8, 8'h10);
    steps_b(3, 15);
    read_row_b(16, row8);
    check("t2_row4_wrap", row8, 8'h00);
    nr_row = 8'h01;
    #1;
    check("t2_next_zero", nr_zero, 8'h02);
    check("t2_next_wrap", nr_wrap, 8'h82);

    // test 4: scrolling under rule 30, new colour
    rule_a = 8'd30; scroll_a = 1'b1;
    frame_edge_a();
    read_row_a(0, row);
    check("t4_scroll_gen1", row, ROW_R30_1);
    color_a = 6'h2A;
    frame_edge_a();
    read_row_a(0, row);
    check("t4_scroll_gen2", row, ROW_R30_2);
    pixel_a(120 + 48 * 4, 0, 1'b1, c); check("t4_colour", c, 6'h2A);
    scroll_a = 1'b0; color_a = 6'h3F;

    // test 5: LFSR fill
    seed_mode_a = 1'b1; seed_req_a = 1'b1; tick(); seed_req_a = 1'b0;
    check("t5_busy_before_fb", busy_a, 1'b0);
    frame_edge_a();
    check("t5_busy_after_fb", busy_a, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      if (busy_a) busy_cnt++;
      if (i == 10) begin
        seed_mode_a = 1'b0; seed_req_a = 1'b1;
      end
      tick();
      seed_req_a = 1'b0;
    end
    check("t5_busy_cycles", busy_cnt, 100);
    rule_a = 8'd110;
    frame_edge_a();
    check("t5_no_refill", busy_a, 1'b0);
    read_row_a(0, row);
    check("t5_lfsr_row", row, lfsr_row(16'hACE1));
    check("t5_lfsr_head", row[15:0], 16'hACE1);
    pixel_a(120, 0, 1'b1, c); check("t5_px120", c, 6'h3F);
    pixel_a(119, 0, 1'b1, c); check("t5_px119", c, 6'h00);
    pixel_a(520, 0, 1'b1, c); check("t5_px520", c, 6'h00);
    pixel_a(121, 0, 1'b0, c); check("t5_blank", c, 6'h00);

    // test 6: reset in the middle of a fill
    seed_mode_a = 1'b1; seed_req_a = 1'b1; tick(); seed_req_a = 1'b0;
    frame_edge_a();
    for (int i = 1; i < 40; i++) tick();
    check("t6_busy_mid", busy_a, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_busy_reset", busy_a, 1'b0);
    check("t6_state_reset", state_a, ST_IDLE);
    check("t6_rule_reset", frame_rule_a, 8'd30);
    check("t6_rgb_reset", vif_a.rgb, 6'd0);
    read_row_a(0, row);
    check("t6_row_reset", row, ROW_C);
    rule_a = 8'd30;
    frame_edge_a();
    check("t6_busy_after_fb", busy_a, 1'b0);
    check("t6_rule_after_fb", frame_rule_a, 8'd30);
    read_row_a(0, row);
    check("t6_row_after_fb", row, ROW_C);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
